ysyx_22050243_ctrl_seq: RTL and testbench
=========================================

# ysyx_22050243_ctrl_seq

Registered, handshaked control sequencer for the NPC decode stage. Accepts a 32-bit instruction word, decodes it into a control bundle one cycle later, and holds that bundle under valid/ready backpressure. Stalls intake while a load/store is outstanding and enters a sticky halt on `ebreak`, with a `halt` output in place of a simulation-side call. It is parametrised for RV32/RV64 and optional CSR support, and flags illegal encodings.

## Interface
- `XLEN`, 64: 64 enables OP_IMM32/OP_32; 32 makes those opcodes illegal.
- `CSR_EN`, 1: 0 makes every SYSTEM instruction other than `ebreak` illegal.
- `MEM_TIMEOUT`, 0: 0 disables the timeout; N>0 aborts a memory wait after N cycles. The counter width is `$clog2(MEM_TIMEOUT+1)`.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `inst_valid`  in  1  upstream instruction valid.
- `inst`  in  32  instruction word.
- `inst_ready`  out  1  intake ready.
- `out_valid`  out  1  control bundle valid.
- `out_ready`  in  1  downstream accepts bundle.
- `ctrl`  out  15  bundle `{illegal, csr_r, alu_src, mem2reg[2:0], reg_w, mem_r, mem_w, branch, pc_src_ctrl[1:0], alu_op[2:0]}`.
- `mem_done`  in  1  memory completion for the outstanding load/store.
- `mem_err`  out  1  one-cycle pulse when a memory wait times out.
- `halt`  out  1  sticky; set after the `ebreak` bundle is accepted.

## Operation
- Decode fields:
  - `mem2reg`: 000 ALU, 001 mem, 010 imm, 011 PC+4, 100 PC+imm, 101 CSR.
  - `pc_src_ctrl`: 00 seq, 01 jal, 10 jalr.
  - `alu_op`: 000 add/none, 001 branch, 010 OP, 011 OP_IMM, 110 OP_32, 111 OP_IMM32.
- Decode per opcode:
  - LUI: `mem2reg`=010, `reg_w`.
  - AUIPC: `mem2reg`=100, `reg_w`.
  - JAL: `mem2reg`=011, `reg_w`, `pc_src_ctrl`=01.
  - JALR: as JAL but `pc_src_ctrl`=10.
  - BRANCH: `branch`, `alu_op`=001.
  - LOAD: `alu_src`, `mem2reg`=001, `reg_w`, `mem_r`.
  - STORE: `alu_src`, `mem_w`.
  - OP_IMM: `alu_src`, `reg_w`, `alu_op`=011.
  - OP: `reg_w`, `alu_op`=010.
  - OP_IMM32: `alu_src`, `reg_w`, `alu_op`=111.
  - OP_32: `reg_w`, `alu_op`=110.
  - FENCE: all zero.
  - SYSTEM with funct3≠000: `csr_r`, `mem2reg`=101, `reg_w`.
  - `ebreak` (exactly 32'h0010_0073): all zero, tagged internally as halting.
- Illegal: `inst[1:0]`≠11, unknown opcode, any other funct3=000 SYSTEM word, or a parameter-disabled opcode. The bundle is then all zero except `illegal`=1 and passes through the normal handshake; it does not halt.
- States:
  - IDLE: `inst_ready`=1, `out_valid`=0. An intake handshake registers the decode and moves to HOLD.
  - HOLD: `out_valid`=1 and the bundle is stable until `out_ready`. On the output handshake the next state depends on the held instruction:
    - load/store → MEM;
    - ebreak → HALT;
    - anything else → IDLE, or stays in HOLD with the new bundle if an intake handshake happens in the same cycle.
  - MEM: `inst_ready`=0, `out_valid`=0, counter increments each cycle. `mem_done`=1 → IDLE. When the counter reaches `MEM_TIMEOUT`, `mem_err` pulses and the state moves to IDLE.
  - HALT: `inst_ready`=0, `out_valid`=0, `halt`=1. Only reset exits.
- `inst_ready` = IDLE, or (HOLD and `out_ready` and held instruction is neither load/store nor ebreak).
- Reset values: state IDLE, `ctrl`=0, `out_valid`=0, `halt`=0, `mem_err`=0, counter 0.

## Timing
- Latency: intake handshake at edge N → `out_valid`=1 and `ctrl` valid from cycle N+1.
- Throughput: one bundle per cycle with `out_ready` held high and no load/store or ebreak.
- `mem_done` is sampled only in MEM. A `mem_done` asserted in the same cycle as the store/load output handshake is ignored.
- The counter resets to 0 on MEM entry.
- If `mem_done` and the timeout coincide, `mem_done` wins and there is no `mem_err`.
- `halt` rises the cycle after the ebreak output handshake.
- `rst_n` low at any point, including mid-MEM or HALT, asynchronously forces the reset values. The first intake is possible on the first edge after release.
- `ctrl` is unchanged while `out_valid`=1 and `out_ready`=0. `inst` changes during a stall are ignored.

## Structure
- Package `ysyx_22050243_ctrl_pkg`:
  - opcode constants (LUI…SYSTEM, FENCE) and the EBREAK word;
  - enums `alu_op_e`, `mem2reg_e`, `pc_src_e`;
  - packed struct `ctrl_t` (15 bits, field order as the `ctrl` port);
  - state enum `seq_state_e`.
- Sub-module `ysyx_22050243_ctrl_dec`: purely combinational; inputs `inst`, parameters `XLEN`/`CSR_EN`; outputs `ctrl_t` plus `is_mem`, `is_ebreak`.
- `ysyx_22050243_ctrl_seq` holds the FSM, bundle register and timeout counter.

## Test plan
- Reset, then `inst`=32'h0000_0513 (addi) with `out_ready`=1 → next cycle `ctrl`: `alu_src`=1, `reg_w`=1, `alu_op`=011, `illegal`=0; back-to-back stream gives one bundle per cycle.
- Load 32'h0000_3503, `out_ready`=1, `mem_done` delayed 5 cycles → `inst_ready`=0 for those cycles; intake resumes the cycle after IDLE re-entry.
- With `MEM_TIMEOUT`=4: store, no `mem_done` → one-cycle `mem_err` 4 cycles into MEM, then IDLE; repeat with `mem_done` on the timeout cycle → no `mem_err`.
- `XLEN`=32: 32'h0010_051B (addiw) → `illegal`=1, all other fields 0, FSM continues.
- `out_ready`=0 for 3 cycles with `inst` toggling → `ctrl` stable, `inst_ready`=0.
- 32'h0010_0073 accepted → `halt`=1 next cycle, `inst_ready`=0. `rst_n` pulse low → `halt`=0 and IDLE.

Source files
------------

// File: rtl/ysyx_22050243_ctrl_pkg.sv
// Shared encodings for the decode-stage control sequencer.
package ysyx_22050243_ctrl_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32    = 7'b0111011;
  localparam logic [6:0] OPC_FENCE    = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

  typedef enum logic [2:0] {
    ALU_ADD      = 3'b000,
    ALU_BRANCH   = 3'b001,
    ALU_OP       = 3'b010,
    ALU_OP_IMM   = 3'b011,
    ALU_OP_32    = 3'b110,
    ALU_OP_IMM32 = 3'b111
  } alu_op_e;

  typedef enum logic [2:0] {
    M2R_ALU   = 3'b000,
    M2R_MEM   = 3'b001,
    M2R_IMM   = 3'b010,
    M2R_PC4   = 3'b011,
    M2R_PCIMM = 3'b100,
    M2R_CSR   = 3'b101
  } mem2reg_e;

  typedef enum logic [1:0] {
    PC_SEQ  = 2'b00,
    PC_JAL  = 2'b01,
    PC_JALR = 2'b10
  } pc_src_e;

  // Field order matches the 15-bit ctrl port, MSB first.
  typedef struct packed {
    logic     illegal;
    logic     csr_r;
    logic     alu_src;
    mem2reg_e mem2reg;
    logic     reg_w;
    logic     mem_r;
    logic     mem_w;
    logic     branch;
    pc_src_e  pc_src_ctrl;
    alu_op_e  alu_op;
  } ctrl_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_HOLD = 2'b01,
    S_MEM  = 2'b10,
    S_HALT = 2'b11
  } seq_state_e;

endpackage

// File: rtl/ysyx_22050243_ctrl_dec.sv
// Combinational instruction decoder producing the control bundle.
module ysyx_22050243_ctrl_dec
  import ysyx_22050243_ctrl_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter bit CSR_EN = 1'b1
) (
  input  logic [31:0] inst,
  output ctrl_t       ctrl,
  output logic        is_mem,
  output logic        is_ebreak
);

  localparam bit RV64 = (XLEN == 64);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       illegal;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];

  // Opcode decode; any illegal word collapses to a bundle carrying only the illegal flag.
  always_comb begin
    ctrl      = '0;
    is_mem    = 1'b0;
    is_ebreak = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OPC_LUI: begin
        ctrl.mem2reg = M2R_IMM;
        ctrl.reg_w   = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl.mem2reg = M2R_PCIMM;
        ctrl.reg_w   = 1'b1;
      end
      OPC_JAL: begin
        ctrl.mem2reg     = M2R_PC4;
        ctrl.reg_w       = 1'b1;
        ctrl.pc_src_ctrl = PC_JAL;
      end
      OPC_JALR: begin
        ctrl.mem2reg     = M2R_PC4;
        ctrl.reg_w       = 1'b1;
        ctrl.pc_src_ctrl = PC_JALR;
      end
      OPC_BRANCH: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALU_BRANCH;
      end
      OPC_LOAD: begin
        ctrl.alu_src = 1'b1;
        ctrl.mem2reg = M2R_MEM;
        ctrl.reg_w   = 1'b1;
        ctrl.mem_r   = 1'b1;
        is_mem       = 1'b1;
      end
      OPC_STORE: begin
        ctrl.alu_src = 1'b1;
        ctrl.mem_w   = 1'b1;
        is_mem       = 1'b1;
      end
      OPC_OP_IMM: begin
        ctrl.alu_src = 1'b1;
        ctrl.reg_w   = 1'b1;
        ctrl.alu_op  = ALU_OP_IMM;
      end
      OPC_OP: begin
        ctrl.reg_w  = 1'b1;
        ctrl.alu_op = ALU_OP;
      end
      OPC_OP_IMM32: begin
        if (RV64) begin
          ctrl.alu_src = 1'b1;
          ctrl.reg_w   = 1'b1;
          ctrl.alu_op  = ALU_OP_IMM32;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_OP_32: begin
        if (RV64) begin
          ctrl.reg_w  = 1'b1;
          ctrl.alu_op = ALU_OP_32;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_FENCE: begin
        ctrl = '0;
      end
      OPC_SYSTEM: begin
        if (inst == EBREAK_WORD) begin
          is_ebreak = 1'b1;
        end else if (CSR_EN && (funct3 != 3'b000)) begin
          ctrl.csr_r   = 1'b1;
          ctrl.mem2reg = M2R_CSR;
          ctrl.reg_w   = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase

    // inst[1:0] != 2'b11 never matches a listed opcode, so it lands in default.
    if (illegal) begin
      ctrl         = '0;
      ctrl.illegal = 1'b1;
      is_mem       = 1'b0;
      is_ebreak    = 1'b0;
    end
  end

endmodule

// File: rtl/ysyx_22050243_ctrl_seq.sv
// Handshaked decode-stage sequencer: registers the decoded bundle, waits out
// memory operations and parks in a sticky halt after ebreak.
//
// state  | meaning
// IDLE   | ready for an instruction, no bundle held
// HOLD   | bundle valid, waiting for downstream to accept it
// MEM    | load/store issued, waiting for mem_done or timeout
// HALT   | ebreak retired; only reset leaves
module ysyx_22050243_ctrl_seq
  import ysyx_22050243_ctrl_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter bit CSR_EN      = 1'b1,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_valid,
  input  logic [31:0] inst,
  output logic        inst_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [14:0] ctrl,
  input  logic        mem_done,
  output logic        mem_err,
  output logic        halt
);

  localparam bit TIMEOUT_EN = (MEM_TIMEOUT > 0);
  // A disabled timeout still needs a legal one-bit counter.
  localparam int CNT_W = TIMEOUT_EN ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_EN ? MEM_TIMEOUT - 1 : 0);

  seq_state_e       state_q, state_d;
  ctrl_t            ctrl_q;
  ctrl_t            dec_ctrl;
  logic             dec_is_mem, dec_is_ebreak;
  logic             held_mem, held_ebreak;
  logic [CNT_W-1:0] cnt_q;
  logic             mem_err_q, halt_q;
  logic             load_bundle, cnt_clr, timeout_hit, set_halt;
  logic             inst_ready_c, out_valid_c;

  ysyx_22050243_ctrl_dec #(
    .XLEN   (XLEN),
    .CSR_EN (CSR_EN)
  ) u_dec (
    .inst      (inst),
    .ctrl      (dec_ctrl),
    .is_mem    (dec_is_mem),
    .is_ebreak (dec_is_ebreak)
  );

  // Next-state and handshake decode.
  always_comb begin
    state_d      = state_q;
    load_bundle  = 1'b0;
    cnt_clr      = 1'b0;
    timeout_hit  = 1'b0;
    set_halt     = 1'b0;
    inst_ready_c = 1'b0;
    out_valid_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        inst_ready_c = 1'b1;
        if (inst_valid) begin
          load_bundle = 1'b1;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        out_valid_c = 1'b1;
        if (out_ready) begin
          if (held_mem) begin
            state_d = S_MEM;
            cnt_clr = 1'b1;
          end else if (held_ebreak) begin
            state_d  = S_HALT;
            set_halt = 1'b1;
          end else begin
            // Plain instruction retiring: accept the next one in the same cycle.
            inst_ready_c = 1'b1;
            if (inst_valid) begin
              load_bundle = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end
      S_MEM: begin
        // mem_done has priority over a coincident timeout.
        if (mem_done) begin
          state_d = S_IDLE;
        end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
          state_d     = S_IDLE;
          timeout_hit = 1'b1;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, held bundle and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ctrl_q      <= '0;
      held_mem    <= 1'b0;
      held_ebreak <= 1'b0;
      mem_err_q   <= 1'b0;
      halt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_err_q <= timeout_hit;
      if (set_halt) begin
        halt_q <= 1'b1;
      end
      if (load_bundle) begin
        ctrl_q      <= dec_ctrl;
        held_mem    <= dec_is_mem;
        held_ebreak <= dec_is_ebreak;
      end
    end
  end

  // Memory wait counter: cleared on MEM entry, counts each MEM cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (TIMEOUT_EN && (state_q == S_MEM)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign inst_ready = inst_ready_c;
  assign out_valid  = out_valid_c;
  assign ctrl       = ctrl_q;
  assign mem_err    = mem_err_q;
  assign halt       = halt_q;

endmodule

// File: tb/tb_ysyx_22050243_ctrl_seq.sv
// Bench for the control sequencer. Two instances share stimulus:
// A = RV64, CSR on, timeout 4; B = RV32, CSR off, no timeout.
module tb_ysyx_22050243_ctrl_seq;

  logic        clk;
  logic        rst_n;
  logic        inst_valid;
  logic [31:0] inst;
  logic        out_ready;
  logic        mem_done;

  logic        inst_ready_a, out_valid_a, mem_err_a, halt_a;
  logic [14:0] ctrl_a;
  logic        inst_ready_b, out_valid_b, mem_err_b, halt_b;
  logic [14:0] ctrl_b;

  int checks = 0;
  int errors = 0;

  logic [14:0] q_a[$];
  logic [14:0] q_b[$];
  logic [14:0] cur_exp_a, cur_exp_b;

  typedef struct {
    logic [31:0] inst;
    logic [14:0] exp_a;
    logic [14:0] exp_b;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  localparam logic [14:0] ILL = 15'h4000;
  localparam logic [31:0] I_ADDI   = 32'h0000_0513;
  localparam logic [31:0] I_LOAD   = 32'h0000_3503;
  localparam logic [31:0] I_STORE  = 32'h00A5_2023;
  localparam logic [31:0] I_EBREAK = 32'h0010_0073;

  ysyx_22050243_ctrl_seq #(.XLEN(64), .CSR_EN(1'b1), .MEM_TIMEOUT(4)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_ready (inst_ready_a),
    .out_valid  (out_valid_a),
    .out_ready  (out_ready),
    .ctrl       (ctrl_a),
    .mem_done   (mem_done),
    .mem_err    (mem_err_a),
    .halt       (halt_a)
  );

  ysyx_22050243_ctrl_seq #(.XLEN(32), .CSR_EN(1'b0), .MEM_TIMEOUT(0)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_ready (inst_ready_b),
    .out_valid  (out_valid_b),
    .out_ready  (out_ready),
    .ctrl       (ctrl_b),
    .mem_done   (mem_done),
    .mem_err    (mem_err_b),
    .halt       (halt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] cw(input logic ill, input logic csr, input logic asrc,
                                     input logic [2:0] m2r, input logic rw, input logic mr,
                                     input logic mw, input logic br, input logic [1:0] pc,
                                     input logic [2:0] op);
    return {ill, csr, asrc, m2r, rw, mr, mw, br, pc, op};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_a(input string tag, input logic ir, input logic ov, input logic me, input logic h);
    chk({tag, " inst_ready_a"}, {31'd0, inst_ready_a}, {31'd0, ir});
    chk({tag, " out_valid_a"}, {31'd0, out_valid_a}, {31'd0, ov});
    chk({tag, " mem_err_a"}, {31'd0, mem_err_a}, {31'd0, me});
    chk({tag, " halt_a"}, {31'd0, halt_a}, {31'd0, h});
  endtask

  task automatic chk_b(input string tag, input logic ir, input logic ov, input logic me, input logic h);
    chk({tag, " inst_ready_b"}, {31'd0, inst_ready_b}, {31'd0, ir});
    chk({tag, " out_valid_b"}, {31'd0, out_valid_b}, {31'd0, ov});
    chk({tag, " mem_err_b"}, {31'd0, mem_err_b}, {31'd0, me});
    chk({tag, " halt_b"}, {31'd0, halt_b}, {31'd0, h});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop/compare on output handshake, push on intake handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      q_a.delete();
      q_b.delete();
    end else begin
      if (out_valid_a && out_ready) begin
        if (q_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_a: unexpected bundle %h, nothing expected", ctrl_a);
        end else begin
          chk("sb_ctrl_a", {17'd0, ctrl_a}, {17'd0, q_a.pop_front()});
        end
      end
      if (out_valid_b && out_ready) begin
        if (q_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_b: unexpected bundle %h, nothing expected", ctrl_b);
        end else begin
          chk("sb_ctrl_b", {17'd0, ctrl_b}, {17'd0, q_b.pop_front()});
        end
      end
      if (inst_valid && inst_ready_a) q_a.push_back(cur_exp_a);
      if (inst_valid && inst_ready_b) q_b.push_back(cur_exp_b);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [14:0] c_addi, c_load, c_store;
    c_addi  = cw(0, 0, 1, 3'b000, 1, 0, 0, 0, 2'b00, 3'b011);
    c_load  = cw(0, 0, 1, 3'b001, 1, 1, 0, 0, 2'b00, 3'b000);
    c_store = cw(0, 0, 1, 3'b000, 0, 0, 1, 0, 2'b00, 3'b000);

    vecs[0]  = '{I_ADDI,        c_addi, c_addi};
    vecs[1]  = '{32'h1234_52B7, cw(0,0,0,3'b010,1,0,0,0,2'b00,3'b000), cw(0,0,0,3'b010,1,0,0,0,2'b00,3'b000)};
    vecs[2]  = '{32'h0000_0297, cw(0,0,0,3'b100,1,0,0,0,2'b00,3'b000), cw(0,0,0,3'b100,1,0,0,0,2'b00,3'b000)};
    vecs[3]  = '{32'h0080_00EF, cw(0,0,0,3'b011,1,0,0,0,2'b01,3'b000), cw(0,0,0,3'b011,1,0,0,0,2'b01,3'b000)};
    vecs[4]  = '{32'h0000_8067, cw(0,0,0,3'b011,1,0,0,0,2'b10,3'b000), cw(0,0,0,3'b011,1,0,0,0,2'b10,3'b000)};
    vecs[5]  = '{32'h00B5_0463, cw(0,0,0,3'b000,0,0,0,1,2'b00,3'b001), cw(0,0,0,3'b000,0,0,0,1,2'b00,3'b001)};
    vecs[6]  = '{32'h00B5_0533, cw(0,0,0,3'b000,1,0,0,0,2'b00,3'b010), cw(0,0,0,3'b000,1,0,0,0,2'b00,3'b010)};
    vecs[7]  = '{32'h0010_051B, cw(0,0,1,3'b000,1,0,0,0,2'b00,3'b111), ILL};
    vecs[8]  = '{32'h00B5_053B, cw(0,0,0,3'b000,1,0,0,0,2'b00,3'b110), ILL};
    vecs[9]  = '{32'h0FF0_000F, 15'h0000, 15'h0000};
    vecs[10] = '{32'h3000_22F3, cw(0,1,0,3'b101,1,0,0,0,2'b00,3'b000), ILL};
    vecs[11] = '{32'h0000_0073, ILL, ILL};
    vecs[12] = '{32'h0000_0512, ILL, ILL};
    vecs[13] = '{32'h0000_007F, ILL, ILL};
    vecs[14] = '{32'h0000_3500, ILL, ILL};
    vecs[15] = '{32'h3020_0073, ILL, ILL};

    rst_n      = 1'b0;
    inst_valid = 1'b0;
    inst       = 32'd0;
    out_ready  = 1'b0;
    mem_done   = 1'b0;
    cur_exp_a  = '0;
    cur_exp_b  = '0;

    // Reset state
    @(negedge clk);
    chk_a("reset", 1, 0, 0, 0);
    chk_b("reset", 1, 0, 0, 0);
    chk("reset ctrl_a", {17'd0, ctrl_a}, 32'd0);
    chk("reset ctrl_b", {17'd0, ctrl_b}, 32'd0);
    step();
    rst_n = 1'b1;

    // Back-to-back decode table, one bundle per cycle
    out_ready  = 1'b1;
    inst_valid = 1'b1;
    for (int i = 0; i < NV; i++) begin
      inst      = vecs[i].inst;
      cur_exp_a = vecs[i].exp_a;
      cur_exp_b = vecs[i].exp_b;
      @(negedge clk);
      if (i > 0) begin
        chk("stream out_valid_a", {31'd0, out_valid_a}, 32'd1);
        chk("stream inst_ready_a", {31'd0, inst_ready_a}, 32'd1);
        chk("stream out_valid_b", {31'd0, out_valid_b}, 32'd1);
        chk("stream inst_ready_b", {31'd0, inst_ready_b}, 32'd1);
      end
      step();
    end
    inst_valid = 1'b0;
    @(negedge clk);
    chk("drain out_valid_a", {31'd0, out_valid_a}, 32'd1);
    step();
    @(negedge clk);
    chk_a("drained", 1, 0, 0, 0);
    chk_b("drained", 1, 0, 0, 0);

    // Backpressure: bundle stable, intake blocked, inst toggling ignored
    inst       = I_ADDI;
    cur_exp_a  = c_addi;
    cur_exp_b  = c_addi;
    inst_valid = 1'b1;
    out_ready  = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      inst = vecs[k + 1].inst;
      @(negedge clk);
      chk_a("stall", 0, 1, 0, 0);
      chk_b("stall", 0, 1, 0, 0);
      chk("stall ctrl_a", {17'd0, ctrl_a}, {17'd0, c_addi});
      chk("stall ctrl_b", {17'd0, ctrl_b}, {17'd0, c_addi});
      step();
    end
    out_ready  = 1'b1;
    inst_valid = 1'b0;
    @(negedge clk);
    step();
    @(negedge clk);
    chk_a("after stall", 1, 0, 0, 0);
    chk_b("after stall", 1, 0, 0, 0);

    // Load: mem_done during the output handshake is ignored; done after 5 cycles.
    // A times out after 4 MEM cycles; B waits for mem_done.
    inst       = I_LOAD;
    cur_exp_a  = c_load;
    cur_exp_b  = c_load;
    inst_valid = 1'b1;
    step();
    inst      = I_ADDI;
    cur_exp_a = c_addi;
    cur_exp_b = c_addi;
    mem_done  = 1'b1;
    @(negedge clk);
    chk_a("load hold", 0, 1, 0, 0);
    chk_b("load hold", 0, 1, 0, 0);
    step();
    inst_valid = 1'b0;
    mem_done   = 1'b0;
    for (int m = 1; m <= 4; m++) begin
      @(negedge clk);
      chk_a("load mem", 0, 0, 0, 0);
      chk_b("load mem", 0, 0, 0, 0);
      step();
    end
    mem_done = 1'b1;
    @(negedge clk);
    chk_a("load timeout", 1, 0, 1, 0);
    chk_b("load mem5", 0, 0, 0, 0);
    step();
    mem_done   = 1'b0;
    inst_valid = 1'b1;
    @(negedge clk);
    chk_a("load resume", 1, 0, 0, 0);
    chk_b("load resume", 1, 0, 0, 0);
    step();
    inst_valid = 1'b0;
    @(negedge clk);
    chk("resume out_valid_a", {31'd0, out_valid_a}, 32'd1);
    chk("resume out_valid_b", {31'd0, out_valid_b}, 32'd1);
    step();

    // Store with mem_done on the timeout cycle: no mem_err
    inst       = I_STORE;
    cur_exp_a  = c_store;
    cur_exp_b  = c_store;
    inst_valid = 1'b1;
    step();
    inst_valid = 1'b0;
    @(negedge clk);
    chk_a("store hold", 0, 1, 0, 0);
    step();
    for (int m = 1; m <= 3; m++) begin
      @(negedge clk);
      chk_a("store mem", 0, 0, 0, 0);
      chk_b("store mem", 0, 0, 0, 0);
      step();
    end
    mem_done = 1'b1;
    @(negedge clk);
    chk_a("store mem4", 0, 0, 0, 0);
    step();
    mem_done = 1'b0;
    @(negedge clk);
    chk_a("store done", 1, 0, 0, 0);
    chk_b("store done", 1, 0, 0, 0);
    step();

    // ebreak: bundle of zeros, halt the cycle after acceptance, reset clears
    inst       = I_EBREAK;
    cur_exp_a  = 15'h0000;
    cur_exp_b  = 15'h0000;
    inst_valid = 1'b1;
    step();
    inst      = I_ADDI;
    cur_exp_a = c_addi;
    cur_exp_b = c_addi;
    @(negedge clk);
    chk_a("ebreak hold", 0, 1, 0, 0);
    chk_b("ebreak hold", 0, 1, 0, 0);
    step();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_a("halted", 0, 0, 0, 1);
      chk_b("halted", 0, 0, 0, 1);
      step();
    end
    rst_n = 1'b0;
    #2;
    chk_a("async reset", 1, 0, 0, 0);
    chk_b("async reset", 1, 0, 0, 0);
    chk("async reset ctrl_a", {17'd0, ctrl_a}, 32'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post reset inst_ready_a", {31'd0, inst_ready_a}, 32'd1);
    step();
    inst_valid = 1'b0;
    @(negedge clk);
    chk("post reset out_valid_a", {31'd0, out_valid_a}, 32'd1);
    chk("post reset out_valid_b", {31'd0, out_valid_b}, 32'd1);
    step();
    step();

    chk("queue_a empty", q_a.size(), 32'd0);
    chk("queue_b empty", q_b.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
